// File: rtl/softmax_host_if.sv
// ---------------------------------------------------------------------------
// softmax_host_if
// Stream bundle between the host and softmax_host_ctrl.
//   s_valid/s_ready/s_data/s_last : frame words going into the core's input buffer
//   m_valid/m_ready/m_data/m_last : result words read back from the output buffer
// Modports:
//   slave  - the controller side (accepts the s_* stream, sources the m_* stream)
//   master - the host side (sources the s_* stream, accepts the m_* stream)
// ---------------------------------------------------------------------------
interface softmax_host_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/softmax_host_ctrl.sv
// ---------------------------------------------------------------------------
// softmax_host_ctrl
// Host-side driver for the softmax core. One frame is:
//   IDLE -> LOAD  : stream TOTAL_WORDS words into the input buffer, core held in reset
//        -> WAIT  : core released, COMPUTE_CYCLES clocks of compute
//        -> DRAIN : output buffer read back through a 2-entry FIFO onto the m_* stream
//        -> IDLE  : done pulses for one cycle
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             1-cycle frame start, honoured only in IDLE
//   io (slave)        s_* input stream, m_* output stream (see softmax_host_if)
//   sm_rst            reset to the softmax core (high in IDLE/LOAD)
//   data_in_*         input buffer write port (registered strobes)
//   data_out_*        output buffer read port, data returns 1 clk after the enable
//   busy, done        not-IDLE flag, end-of-frame pulse
//   err_len           only with SOFTMAX_HOST_LEN_CHK_EN: sticky frame length error
// Build option:
//   SOFTMAX_HOST_LEN_CHK_EN - checks s_last against the frame length and adds err_len.
// ---------------------------------------------------------------------------
module softmax_host_ctrl #(
  parameter int TOTAL_WORDS    = 1024,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int COMPUTE_CYCLES = 3200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  softmax_host_if.slave         io,
  output logic                  sm_rst,
  output logic                  data_in_enable,
  output logic                  data_in_wr_enable,
  output logic [ADDR_WIDTH-1:0] data_in_address,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_out_enable,
  output logic [ADDR_WIDTH-1:0] data_out_address,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
`ifdef SOFTMAX_HOST_LEN_CHK_EN
  output logic                  err_len,
`endif
  output logic                  done
);

  localparam int CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   RD_END   = (ADDR_WIDTH + 1)'(TOTAL_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;     // one extra bit so it can reach TOTAL_WORDS
  logic [ADDR_WIDTH-1:0] out_cnt_reg;
  logic [CW-1:0]         wait_cnt_reg;
  logic                  data_in_enable_reg;
  logic [ADDR_WIDTH-1:0] data_in_address_reg;
  logic [DATA_WIDTH-1:0] data_in_reg;
  logic                  inflight_reg;   // a read was issued last cycle
  logic [1:0]            fifo_cnt_reg;
  logic                  fifo_wr_idx_reg;
  logic                  fifo_rd_idx_reg;
  logic                  done_reg;

  logic                  s_ready_w;
  logic                  s_hs;
  logic                  m_valid_w;
  logic                  m_hs;
  logic                  last_in;
  logic                  last_out;
  logic                  rd_issue;
  logic                  fifo_push;
  logic [2:0]            occ;
  logic                  len_early;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign last_in   = (wr_ptr_reg == LAST_IDX);
  assign last_out  = (out_cnt_reg == LAST_IDX);
  assign s_hs      = s_ready_w && io.s_valid;
  assign m_valid_w = (fifo_cnt_reg != 2'd0);
  assign m_hs      = m_valid_w && io.m_ready;
  assign fifo_push = inflight_reg;

  // Occupancy counts words already buffered plus the one returning from the
  // RAM, minus the word leaving this cycle; subtracting the pop is what lets
  // a continuously-ready sink see one word per clock.
  assign occ = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg} - {2'b00, m_hs};

`ifdef SOFTMAX_HOST_LEN_CHK_EN
  logic err_len_reg;
  logic len_missing;
  assign len_early   = s_hs && io.s_last && !last_in;
  assign len_missing = s_hs && !io.s_last && last_in;
  assign err_len     = err_len_reg;
`else
  logic unused_s_last;
  assign unused_s_last = io.s_last;
  assign len_early     = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- next state / combinational outputs ----------------
  always_comb begin
    state_next = state_reg;
    s_ready_w  = 1'b0;
    sm_rst     = 1'b1;
    rd_issue   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready_w = 1'b1;
        if (s_hs) begin
          if (len_early)    state_next = ST_IDLE;
          else if (last_in) state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        sm_rst = 1'b0;
        if (wait_cnt_reg == '0) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        sm_rst   = 1'b0;
        rd_issue = (rd_ptr_reg < RD_END) && (occ < 3'd2);
        if (m_hs && last_out) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg          <= '0;
      rd_ptr_reg          <= '0;
      out_cnt_reg         <= '0;
      wait_cnt_reg        <= '0;
      data_in_enable_reg  <= 1'b0;
      data_in_address_reg <= '0;
      data_in_reg         <= '0;
      inflight_reg        <= 1'b0;
      fifo_cnt_reg        <= 2'd0;
      fifo_wr_idx_reg     <= 1'b0;
      fifo_rd_idx_reg     <= 1'b0;
      done_reg            <= 1'b0;
    end else begin
      data_in_enable_reg <= 1'b0;
      done_reg           <= 1'b0;
      inflight_reg       <= rd_issue;

      if (state_reg == ST_IDLE && start) wr_ptr_reg <= '0;

      if (s_hs) begin
        data_in_enable_reg  <= 1'b1;
        data_in_address_reg <= wr_ptr_reg;
        data_in_reg         <= io.s_data;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end

      if (state_reg == ST_LOAD && state_next == ST_WAIT)
        wait_cnt_reg <= CW'(COMPUTE_CYCLES - 1);
      else if (state_reg == ST_WAIT && wait_cnt_reg != '0)
        wait_cnt_reg <= wait_cnt_reg - 1'b1;

      if (state_reg == ST_WAIT && state_next == ST_DRAIN) begin
        rd_ptr_reg  <= '0;
        out_cnt_reg <= '0;
      end else begin
        if (rd_issue) rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        if (m_hs)     out_cnt_reg <= out_cnt_reg + 1'b1;
      end

      case ({fifo_push, m_hs})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
      if (fifo_push) fifo_wr_idx_reg <= ~fifo_wr_idx_reg;
      if (m_hs)      fifo_rd_idx_reg <= ~fifo_rd_idx_reg;

      if (m_hs && last_out) done_reg <= 1'b1;
    end
  end

`ifdef SOFTMAX_HOST_LEN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_len_reg <= 1'b0;
    else if (len_early || len_missing)      err_len_reg <= 1'b1;
    else if (state_reg == ST_IDLE && start) err_len_reg <= 1'b0;
  end
`endif

  // ---------------- 2-entry output FIFO ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [DATA_WIDTH-1:0] entry_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        entry_reg <= '0;
      else if (fifo_push && fifo_wr_idx_reg == 1'(gi))
        entry_reg <= data_out;
    end
  end

  assign fifo_head = fifo_rd_idx_reg ? g_fifo[1].entry_reg : g_fifo[0].entry_reg;

  // ---------------- output assignments ----------------
  assign io.s_ready        = s_ready_w;
  assign io.m_valid        = m_valid_w;
  assign io.m_data         = fifo_head;
  assign io.m_last         = m_valid_w && last_out;
  assign data_in_enable    = data_in_enable_reg;
  assign data_in_wr_enable = data_in_enable_reg;
  assign data_in_address   = data_in_address_reg;
  assign data_in           = data_in_reg;
  assign data_out_enable   = rd_issue;
  assign data_out_address  = rd_ptr_reg[ADDR_WIDTH-1:0];
  assign busy              = (state_reg != ST_IDLE);
  assign done              = done_reg;

endmodule

// File: tb/tb_softmax_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_softmax_host_ctrl
// Directed bench for softmax_host_ctrl with TOTAL_WORDS=16, COMPUTE_CYCLES=40.
// Behavioural RAMs stand in for the input and output buffers. A negedge
// monitor checks every buffer write and every output handshake; the main
// thread drives frames and checks state-level behaviour.
// ---------------------------------------------------------------------------
module tb_softmax_host_ctrl;
  localparam int TW = 16;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CC = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  softmax_host_if #(.DATA_WIDTH(DW)) sif ();

  logic          sm_rst, die, diwe, doe, busy, done;
  logic [AW-1:0] dia, doa;
  logic [DW-1:0] din, dout;
`ifdef SOFTMAX_HOST_LEN_CHK_EN
  logic          err_len;
`endif

  softmax_host_ctrl #(
    .TOTAL_WORDS(TW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COMPUTE_CYCLES(CC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .io(sif), .sm_rst(sm_rst),
    .data_in_enable(die), .data_in_wr_enable(diwe), .data_in_address(dia),
    .data_in(din), .data_out_enable(doe), .data_out_address(doa),
    .data_out(dout), .busy(busy),
`ifdef SOFTMAX_HOST_LEN_CHK_EN
    .err_len(err_len),
`endif
    .done(done)
  );

  // Buffer models
  logic [DW-1:0] in_ram  [TW];
  logic [DW-1:0] out_ram [TW];
  always @(posedge clk) begin
    if (die && diwe) in_ram[dia] <= din;
    if (doe)         dout <= out_ram[doa];
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [DW-1:0] in_base  = '0;
  logic [DW-1:0] out_base = '0;
  int            wr_idx = 0;
  int            out_idx = 0;
  int            frame_outs = 0;
  int            done_cnt = 0;
  logic          exp_done = 1'b0;
  logic          stall_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      wr_idx = 0; out_idx = 0; exp_done = 1'b0; stall_pend = 1'b0;
    end else begin
      if (die) begin
        chk("wr_en", {31'd0, diwe}, 32'd1);
        chk("wr_addr", {28'd0, dia}, wr_idx);
        chk("wr_data", din, in_base + wr_idx);
        chk("sm_rst_at_wr", {31'd0, sm_rst}, (wr_idx == TW-1) ? 32'd0 : 32'd1);
        wr_idx++;
      end
      if (done || exp_done) begin
        chk("done", {31'd0, done}, {31'd0, exp_done});
        if (exp_done) begin frame_outs = out_idx; done_cnt++; end
      end
      exp_done = 1'b0;
      if (stall_pend) begin
        chk("stall_valid", {31'd0, sif.m_valid}, 32'd1);
        chk("stall_data", sif.m_data, stall_data);
      end
      stall_pend = 1'b0;
      if (sif.m_valid && sif.m_ready) begin
        $display("out[%0d] = %h last=%0b", out_idx, sif.m_data, sif.m_last);
        chk("m_data", sif.m_data, out_base + out_idx);
        chk("m_last", {31'd0, sif.m_last}, (out_idx == TW-1) ? 32'd1 : 32'd0);
        if (out_idx == TW-1) exp_done = 1'b1;
        out_idx++;
      end else if (sif.m_valid) begin
        stall_pend = 1'b1;
        stall_data = sif.m_data;
      end
      if (!busy) begin wr_idx = 0; out_idx = 0; end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Streams words 0..n_words-1; s_last on index last_at; gap=1 offers a word
  // on one clock in three.
  task automatic load(input int gap, input int last_at, input int n_words);
    int   idx = 0;
    int   cyc = 0;
    logic hs;
    while (idx < n_words && cyc < 200) begin
      sif.s_valid = (gap == 0) || (cyc % 3 == 0);
      sif.s_data  = in_base + idx;
      sif.s_last  = (idx == last_at);
      hs = sif.s_valid && sif.s_ready;
      tick;
      cyc++;
      if (hs) idx++;
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    if (cyc >= 200) chk("load_timeout", 32'd1, 32'd0);
  endtask

  // Entered in the first WAIT cycle; returns in the first DRAIN cycle.
  task automatic wait_compute;
    int n = 0;
    chk("sm_rst_wait", {31'd0, sm_rst}, 32'd0);
    chk("s_ready_wait", {31'd0, sif.s_ready}, 32'd0);
    while (!doe && n < 100) begin tick; n++; end
    chk("wait_len", n, CC);
    chk("wr_count", wr_idx, TW);
    for (int i = 0; i < TW; i++) chk("in_ram", in_ram[i], in_base + i);
  endtask

  // rmode 0: m_ready held 1; rmode 1: pattern 1,0,0,1 repeating.
  task automatic drain(input int rmode);
    int k = 0;
    int d0;
    d0 = done_cnt;
    while (done_cnt == d0 && k < 300) begin
      sif.m_ready = (rmode == 0) || (k % 4 == 0) || (k % 4 == 3);
      tick;
      k++;
    end
    sif.m_ready = 1'b0;
    if (k >= 300) chk("drain_timeout", 32'd1, 32'd0);
    chk("frame_outs", frame_outs, TW);
    if (rmode == 0) chk("drain_cycles", k, TW + 3);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("sm_rst_after", {31'd0, sm_rst}, 32'd1);
  endtask

  task automatic set_bases(input logic [DW-1:0] ib, input logic [DW-1:0] ob);
    in_base  = ib;
    out_base = ob;
    for (int i = 0; i < TW; i++) out_ram[i] = ob + i;
  endtask

  task automatic run_frame(input int gap, input int rmode,
                           input logic [DW-1:0] ib, input logic [DW-1:0] ob);
    set_bases(ib, ob);
    pulse_start;
    chk("busy_load", {31'd0, busy}, 32'd1);
    chk("s_ready_load", {31'd0, sif.s_ready}, 32'd1);
`ifdef SOFTMAX_HOST_LEN_CHK_EN
    chk("err_len_clr", {31'd0, err_len}, 32'd0);
`endif
    load(gap, TW-1, TW);
    wait_compute;
    drain(rmode);
    $display("frame in_base=%h out_base=%h complete", ib, ob);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    sif.m_ready = 1'b0;
    for (int i = 0; i < TW; i++) begin in_ram[i] = '0; out_ram[i] = '0; end

    // 1. reset behaviour, start ignored while in reset
    tick; tick;
    start = 1'b1; tick; start = 1'b0; tick;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sm_rst", {31'd0, sm_rst}, 32'd1);
    chk("rst_s_ready", {31'd0, sif.s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("rst_m_last", {31'd0, sif.m_last}, 32'd0);
    chk("rst_m_data", sif.m_data, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_die", {30'd0, die, diwe}, 32'd0);
    chk("rst_dia", {28'd0, dia}, 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_doe", {31'd0, doe}, 32'd0);
    chk("rst_doa", {28'd0, doa}, 32'd0);
`ifdef SOFTMAX_HOST_LEN_CHK_EN
    chk("rst_err_len", {31'd0, err_len}, 32'd0);
`endif
    rst = 1'b0;
    tick;
    chk("idle_after_rst", {31'd0, busy}, 32'd0);
    $display("reset checks complete");

    // 2. basic frame, data 0..15, m_ready=1
    run_frame(0, 0, 32'h0, 32'hA500_0000);
    // 3. output backpressure 1,0,0,1
    run_frame(0, 1, 32'h0000_0100, 32'h5A00_0000);
    // 4. input gaps
    run_frame(1, 0, 32'h0000_0200, 32'h3300_0000);

    // 5. reset during DRAIN after 5 words
    set_bases(32'h0000_0300, 32'h6600_0000);
    pulse_start;
    load(0, TW-1, TW);
    wait_compute;
    sif.m_ready = 1'b1;
    k = 0;
    while (out_idx < 5 && k < 50) begin tick; k++; end
    if (k >= 50) chk("drain5_timeout", 32'd1, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_m_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("abort_sm_rst", {31'd0, sm_rst}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_doe", {31'd0, doe}, 32'd0);
    sif.m_ready = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    $display("reset abort checks complete");
    run_frame(0, 0, 32'h0000_0400, 32'h7700_0000);

`ifdef SOFTMAX_HOST_LEN_CHK_EN
    // 6. early s_last on word 7 aborts the frame
    set_bases(32'h0000_0500, 32'h1100_0000);
    pulse_start;
    load(0, 7, 8);
    chk("early_err_len", {31'd0, err_len}, 32'd1);
    chk("early_busy", {31'd0, busy}, 32'd0);
    chk("early_sm_rst", {31'd0, sm_rst}, 32'd1);
    chk("early_s_ready", {31'd0, sif.s_ready}, 32'd0);
    tick; tick;
    chk("err_len_sticky", {31'd0, err_len}, 32'd1);
    run_frame(0, 0, 32'h0000_0600, 32'h2200_0000);
    // missing s_last on the final word: flagged, frame still completes
    set_bases(32'h0000_0700, 32'h4400_0000);
    pulse_start;
    load(0, -1, TW);
    chk("missing_err_len", {31'd0, err_len}, 32'd1);
    wait_compute;
    drain(0);
    chk("missing_err_kept", {31'd0, err_len}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
